// File: rtl/prog_loader_pkg.sv
// Shared types and default geometry for the program loader.
package prog_loader_pkg;

    localparam int unsigned DEPTH_DEF = 16;
    localparam int unsigned AW_DEF    = 4;
    localparam int unsigned DW_DEF    = 8;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StLoaded,
        StRun,
        StDone,
        StCheck,
        StErr
    } state_e;

endpackage

// File: rtl/loader_fsm.sv
// Loader control FSM: state register plus next-state and output decode.
// CHECK/ERR are only entered when PROG_LOADER_CHECKSUM_EN is defined.
module loader_fsm
    import prog_loader_pkg::*;
#(
    parameter bit AUTO_RUN = 1'b1
) (
    input  logic CLK,
    input  logic RST,
    input  logic load_start,
    input  logic cpu_halt,
    input  logic full,
    input  logic chk_hs,
    input  logic chk_ok,
    output logic mode,
    output logic cpu_rst,
    output logic busy,
    output logic done,
    output logic err,
    output logic load_en,
    output logic chk_en,
    output logic clear
);

    state_e state_q, state_d;

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode    = 1'b1;
        cpu_rst = 1'b1;
        busy    = 1'b0;
        done    = 1'b0;
        err     = 1'b0;
        load_en = 1'b0;
        chk_en  = 1'b0;
        clear   = 1'b0;
        case (state_q)
            StIdle: begin
                if (load_start) begin
                    state_d = StLoad;
                    clear   = 1'b1;
                end
            end
            StLoad: begin
                busy    = 1'b1;
                load_en = 1'b1;
                if (full) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = StCheck;
`else
                    state_d = AUTO_RUN ? StRun : StLoaded;
`endif
                end
            end
            StLoaded: begin
                if (load_start) state_d = StRun;
            end
            StRun: begin
                mode    = 1'b0;
                cpu_rst = 1'b0;
                // A new load request takes priority over a halt in the same cycle.
                if (load_start) begin
                    state_d = StLoad;
                    clear   = 1'b1;
                end else if (cpu_halt) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                mode    = 1'b0;
                cpu_rst = 1'b0;
                done    = 1'b1;
                if (load_start) begin
                    state_d = StLoad;
                    clear   = 1'b1;
                end
            end
            StCheck: begin
                busy   = 1'b1;
                chk_en = 1'b1;
                if (chk_hs) begin
                    if (chk_ok) state_d = AUTO_RUN ? StRun : StLoaded;
                    else        state_d = StErr;
                end
            end
            StErr: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                err = 1'b1;
`endif
                if (load_start) begin
                    state_d = StLoad;
                    clear   = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

endmodule

// File: rtl/prog_loader.sv
// Streams a program image into the CPU RAM programming port, then releases the CPU.
// Define PROG_LOADER_CHECKSUM_EN to require a trailing mod-256 checksum byte.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int unsigned DEPTH    = DEPTH_DEF,
    parameter int unsigned AW       = AW_DEF,
    parameter int unsigned DW       = DW_DEF,
    parameter bit          AUTO_RUN = 1'b1
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          load_start,
    input  logic          rx_valid,
    input  logic [DW-1:0] rx_data,
    output logic          rx_ready,
    input  logic          cpu_halt,
    output logic          mode,
    output logic          wen,
    output logic [AW-1:0] addr,
    output logic [DW-1:0] instr,
    output logic          cpu_rst,
    output logic          busy,
    output logic          done,
    output logic          err
);

    // Counter is one bit wider than the address so a full image is representable.
    localparam logic [AW:0] FullCnt = (AW + 1)'(DEPTH);
    localparam logic [AW:0] OneCnt  = (AW + 1)'(1);

    logic [AW:0] count_q;
    logic        load_en, chk_en, clear, full;
    logic        hs, load_hs, chk_hs, chk_ok;

    assign full     = (count_q == FullCnt);
    assign rx_ready = (load_en & ~full) | chk_en;
    assign hs       = rx_valid & rx_ready;
    assign load_hs  = hs & load_en;
    assign chk_hs   = hs & chk_en;

    always_ff @(posedge CLK) begin
        if (RST) begin
            count_q <= '0;
            wen     <= 1'b0;
            addr    <= '0;
            instr   <= '0;
        end else begin
            wen <= load_hs;
            if (clear) begin
                count_q <= '0;
            end else if (load_hs) begin
                count_q <= count_q + OneCnt;
            end
            if (load_hs) begin
                addr  <= count_q[AW-1:0];
                instr <= rx_data;
            end
        end
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge CLK) begin
        if (RST || clear) begin
            sum_q <= '0;
        end else if (load_hs) begin
            sum_q <= sum_q + rx_data[7:0];
        end
    end

    assign chk_ok = (rx_data[7:0] == sum_q);
`else
    assign chk_ok = 1'b0;
`endif

    loader_fsm #(
        .AUTO_RUN(AUTO_RUN)
    ) u_fsm (
        .CLK       (CLK),
        .RST       (RST),
        .load_start(load_start),
        .cpu_halt  (cpu_halt),
        .full      (full),
        .chk_hs    (chk_hs),
        .chk_ok    (chk_ok),
        .mode      (mode),
        .cpu_rst   (cpu_rst),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .load_en   (load_en),
        .chk_en    (chk_en),
        .clear     (clear)
    );

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: write scoreboard, control vector table, corner sequences.
module tb_prog_loader;

`ifdef PROG_LOADER_CHECKSUM_EN
    localparam int NB = 17;
`else
    localparam int NB = 16;
`endif

    logic       clk = 1'b0;
    logic       rst, load_start, load_start_b, rx_valid, cpu_halt;
    logic [7:0] rx_data;

    logic       rx_ready, mode, wen, cpu_rst, busy, done, err;
    logic [3:0] addr;
    logic [7:0] instr;

    logic       rx_ready_b, mode_b, wen_b, cpu_rst_b, busy_b, done_b, err_b;
    logic [3:0] addr_b;
    logic [7:0] instr_b;

    always #5 clk = ~clk;

    prog_loader #(.DEPTH(16), .AW(4), .DW(8), .AUTO_RUN(1'b1)) u_dut (
        .CLK(clk), .RST(rst), .load_start(load_start), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready), .cpu_halt(cpu_halt), .mode(mode),
        .wen(wen), .addr(addr), .instr(instr), .cpu_rst(cpu_rst), .busy(busy),
        .done(done), .err(err)
    );

    prog_loader #(.DEPTH(16), .AW(4), .DW(8), .AUTO_RUN(1'b0)) u_dut_man (
        .CLK(clk), .RST(rst), .load_start(load_start_b), .rx_valid(rx_valid),
        .rx_data(rx_data), .rx_ready(rx_ready_b), .cpu_halt(cpu_halt), .mode(mode_b),
        .wen(wen_b), .addr(addr_b), .instr(instr_b), .cpu_rst(cpu_rst_b), .busy(busy_b),
        .done(done_b), .err(err_b)
    );

    typedef struct {
        string name;
        bit    ls;
        bit    halt;
        bit    e_mode;
        bit    e_cpu_rst;
        bit    e_done;
        bit    e_busy;
        bit    e_rdy;
    } vec_t;

    vec_t        vecs[5];
    logic [7:0]  img[17];
    logic [11:0] sb_q[$];
    int          tests = 0;
    int          fails = 0;
    int          wr_idx = 0;
    bit          exp_wen_next = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Negedge sample: write latency, scoreboard pop, and push of any accepted data byte.
    task automatic sample();
        logic [11:0] e;
        @(negedge clk);
        chk("wen_latency", 32'(wen), 32'(exp_wen_next));
        if (wen) begin
            if (sb_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL sb_unexpected_write: got addr %0h data %0h expected none", addr, instr);
            end else begin
                e = sb_q.pop_front();
                chk("wr_addr", 32'(addr), 32'(e[11:8]));
                chk("wr_data", 32'(instr), 32'(e[7:0]));
            end
        end
        exp_wen_next = 1'b0;
        if (rx_valid && rx_ready) begin
            if (wr_idx < 16) begin
                sb_q.push_back({4'(wr_idx), img[wr_idx]});
                exp_wen_next = 1'b1;
            end
            wr_idx++;
        end
    endtask

    task automatic set_img(input logic [7:0] base, input logic [7:0] inc);
        logic [7:0] s;
        s = 8'h00;
        for (int i = 0; i < 16; i++) begin
            img[i] = base + inc * 8'(i);
            s = s + img[i];
        end
        img[16] = s;
    endtask

    task automatic stream(input int n, input bit toggle);
        int sent = 0;
        int cyc = 0;
        wr_idx = 0;
        while (sent < n && cyc < 100) begin
            rx_valid = !toggle || (cyc % 2 == 0);
            rx_data  = img[sent];
            sample();
            if (rx_valid && rx_ready) sent++;
            step();
            cyc++;
        end
        rx_valid = 1'b0;
        chk("stream_bytes_accepted", 32'(sent), 32'(n));
    endtask

    task automatic end_of_load(input bit exp_err);
`ifdef PROG_LOADER_CHECKSUM_EN
        sample();
        if (exp_err) begin
            chk("ck_bad_err", 32'(err), 1);
            chk("ck_bad_mode", 32'(mode), 1);
            chk("ck_bad_cpu_rst", 32'(cpu_rst), 1);
            chk("ck_bad_rdy", 32'(rx_ready), 0);
        end else begin
            chk("ck_ok_mode", 32'(mode), 0);
            chk("ck_ok_cpu_rst", 32'(cpu_rst), 0);
            chk("ck_ok_err", 32'(err), 0);
            chk("ck_ok_busy", 32'(busy), 0);
        end
        step();
`else
        sample();
        chk("last_wr_rdy", 32'(rx_ready), 0);
        chk("last_wr_mode", 32'(mode), 1);
        step();
        sample();
        chk("run_mode", 32'(mode), 0);
        chk("run_cpu_rst", 32'(cpu_rst), 0);
        chk("run_rdy", 32'(rx_ready), 0);
        chk("run_busy", 32'(busy), 0);
        chk("run_err", 32'(err), exp_err);
        step();
`endif
    endtask

    task automatic check_reset();
        chk("rst_mode", 32'(mode), 1);
        chk("rst_wen", 32'(wen), 0);
        chk("rst_addr", 32'(addr), 0);
        chk("rst_instr", 32'(instr), 0);
        chk("rst_rdy", 32'(rx_ready), 0);
        chk("rst_cpu_rst", 32'(cpu_rst), 1);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
    endtask

    task automatic pulse_start();
        load_start = 1'b1;
        sample();
        step();
        load_start = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; load_start = 1'b0; load_start_b = 1'b0;
        rx_valid = 1'b0; rx_data = 8'h00; cpu_halt = 1'b0;
        vecs[0] = '{"run_idle",    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{"halt_done",   1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2] = '{"done_hold",   1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{"done_reload", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
        vecs[4] = '{"load_ignore", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};

        repeat (3) step();
        check_reset();
        rst = 1'b0;

        // IDLE must ignore a valid source byte.
        rx_valid = 1'b1;
        sample();
        step();
        chk("idle_rdy", 32'(rx_ready), 0);
        rx_valid = 1'b0;

        // Image 1, back-to-back; manual-run instance loads the same stream.
        set_img(8'h1E, 8'h11);
        load_start_b = 1'b1;
        pulse_start();
        load_start_b = 1'b0;
        chk("load_busy", 32'(busy), 1);
        chk("load_rdy", 32'(rx_ready), 1);
        stream(NB, 1'b0);
        end_of_load(1'b0);

        chk("man_mode", 32'(mode_b), 1);
        chk("man_cpu_rst", 32'(cpu_rst_b), 1);
        chk("man_rdy", 32'(rx_ready_b), 0);
        chk("man_busy", 32'(busy_b), 0);
        chk("man_flags", 32'({done_b, err_b, wen_b}), 0);
        chk("man_last_addr", 32'(addr_b), 15);
        chk("man_last_instr", 32'(instr_b), 32'(img[15]));
        repeat (3) begin
            sample();
            step();
        end
        chk("man_still_loaded", 32'(mode_b), 1);
        load_start_b = 1'b1;
        sample();
        step();
        load_start_b = 1'b0;
        chk("man_run_mode", 32'(mode_b), 0);
        chk("man_run_cpu_rst", 32'(cpu_rst_b), 0);

        // RUN / DONE / reload control vectors.
        for (int i = 0; i < 5; i++) begin
            load_start = vecs[i].ls;
            cpu_halt   = vecs[i].halt;
            sample();
            step();
            load_start = 1'b0;
            cpu_halt   = 1'b0;
            chk({vecs[i].name, "_mode"}, 32'(mode), 32'(vecs[i].e_mode));
            chk({vecs[i].name, "_cpu_rst"}, 32'(cpu_rst), 32'(vecs[i].e_cpu_rst));
            chk({vecs[i].name, "_done"}, 32'(done), 32'(vecs[i].e_done));
            chk({vecs[i].name, "_busy"}, 32'(busy), 32'(vecs[i].e_busy));
            chk({vecs[i].name, "_rdy"}, 32'(rx_ready), 32'(vecs[i].e_rdy));
        end

        // Image 2 with rx_valid toggling; scoreboard demands addr from 0.
        set_img(8'hA5, 8'h07);
        stream(NB, 1'b1);
        end_of_load(1'b0);

        // load_start in RUN aborts execution.
        pulse_start();
        chk("abort_mode", 32'(mode), 1);
        chk("abort_cpu_rst", 32'(cpu_rst), 1);
        chk("abort_busy", 32'(busy), 1);

        // RST after byte 7 mid-load.
        set_img(8'h3C, 8'h05);
        stream(8, 1'b0);
        sample();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check_reset();

        set_img(8'h90, 8'h13);
        pulse_start();
        stream(NB, 1'b0);
        end_of_load(1'b0);

`ifdef PROG_LOADER_CHECKSUM_EN
        set_img(8'h01, 8'h00);
        pulse_start();
        stream(17, 1'b0);
        end_of_load(1'b0);

        img[16] = 8'h11;
        pulse_start();
        stream(17, 1'b0);
        end_of_load(1'b1);
        repeat (3) begin
            sample();
            step();
        end
        chk("err_hold", 32'(err), 1);
        pulse_start();
        chk("err_reload_busy", 32'(busy), 1);
        chk("err_reload_err", 32'(err), 0);
`else
        chk("no_ck_err", 32'(err), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
